// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard arbitration, stall vector and flush/redirect control.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.

`ifndef STALL_WIDTH
`define STALL_WIDTH 4
`endif
`ifndef STALL_PC
`define STALL_PC 0
`endif
`ifndef STALL_IF
`define STALL_IF 1
`endif
`ifndef STALL_ID
`define STALL_ID 2
`endif
`ifndef STALL_EX
`define STALL_EX 3
`endif

module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    int_req_i,
    input  logic [31:0]             int_addr_i,
    input  logic                    jump_req_i,
    input  logic [31:0]             jump_addr_i,
    input  logic                    hold_ex_req_i,
    input  logic                    load_use_i,
    output logic [`STALL_WIDTH-1:0] stall_o,
    output logic                    flush_o,
    output logic [31:0]             flush_addr_o,
    output logic                    ex_bubble_o,
    output logic [31:0]             stall_cnt_o,
    output logic [31:0]             flush_cnt_o
);

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_REDIRECT = 1'b1;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    localparam int D_INT   = 0;
    localparam int D_JUMP  = 1;
    localparam int D_DRAIN = 2;
    localparam int D_HOLD  = 3;
    localparam int D_LOAD  = 4;
    localparam int D_NONE  = 5;

    logic [0:0] state_q;
    logic [0:0] state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [5:0] dec;
    logic       redirect;
    logic       in_redirect;

    assign redirect    = int_req_i | jump_req_i;
    assign in_redirect = (state_q == S_REDIRECT);

    // Resolve hazard sources by priority into a one-hot decision
    always_comb begin
        dec = '0;
        if (!rst_n) begin
            dec[D_NONE] = 1'b1;
        end else if (int_req_i) begin
            dec[D_INT] = 1'b1;
        end else if (jump_req_i) begin
            dec[D_JUMP] = 1'b1;
        end else if (in_redirect) begin
            dec[D_DRAIN] = 1'b1;
        end else if (hold_ex_req_i) begin
            dec[D_HOLD] = 1'b1;
        end else if (load_use_i) begin
            dec[D_LOAD] = 1'b1;
        end else begin
            dec[D_NONE] = 1'b1;
        end
    end

    // Drive the hazard outputs from the resolved decision
    always_comb begin
        stall_o      = '0;
        flush_o      = 1'b0;
        flush_addr_o = 32'h0;
        ex_bubble_o  = 1'b0;
        unique case (1'b1)
            dec[D_INT]: begin
                flush_o      = 1'b1;
                flush_addr_o = int_addr_i;
            end
            dec[D_JUMP]: begin
                flush_o      = 1'b1;
                flush_addr_o = jump_addr_i;
            end
            dec[D_DRAIN]: begin
                flush_o = 1'b1;
            end
            dec[D_HOLD]: begin
                stall_o[`STALL_PC] = 1'b1;
                stall_o[`STALL_IF] = 1'b1;
                stall_o[`STALL_ID] = 1'b1;
                stall_o[`STALL_EX] = 1'b1;
            end
            dec[D_LOAD]: begin
                stall_o[`STALL_PC] = 1'b1;
                stall_o[`STALL_IF] = 1'b1;
                stall_o[`STALL_ID] = 1'b1;
                ex_bubble_o        = 1'b1;
            end
            dec[D_NONE]: begin
            end
            default: begin
            end
        endcase
    end

    // Stretch each redirect flush; a new request restarts the count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (redirect) begin
            if (FLUSH_RELOAD == 4'd0) begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end else begin
                state_d = S_REDIRECT;
                cnt_d   = FLUSH_RELOAD;
            end
        end else if (in_redirect) begin
            if (cnt_q <= 4'd1) begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    // Flush state and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Count stalled cycles and redirect request cycles, wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            if (|stall_o) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redirect) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = rst_n ? stall_cnt_q : 32'h0;
    assign flush_cnt_o = rst_n ? flush_cnt_q : 32'h0;
`else
    assign stall_cnt_o = 32'h0;
    assign flush_cnt_o = 32'h0;
`endif

endmodule
